// File: rtl/eca_rule_engine_pkg.sv
// Shared types and helpers for the elementary cellular automaton engine.
//   fsm_t    : run-control states (IDLE, RUN)
//   rule_idx : maps a 3-bit {l,c,r} neighbourhood to its rule bit position
package eca_rule_engine_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } fsm_t;

  // Rule bit 7 holds the result for pattern 000 and bit 0 the result for 111.
  // This is the reverse of the Wolfram numbering.
  function automatic logic [2:0] rule_idx(input logic [2:0] pat);
    return 3'd7 - pat;
  endfunction

endpackage

// File: rtl/eca_rule_engine_cell.sv
// One automaton cell: combinational 3-input rule lookup.
//   l, c, r : left neighbour, this cell, right neighbour (current generation)
//   rule    : 8-bit rule table
//   nxt     : this cell's value in the next generation
module eca_cell
  import eca_rule_engine_pkg::*;
(
  input  logic       l,
  input  logic       c,
  input  logic       r,
  input  logic [7:0] rule,
  output logic       nxt
);

  assign nxt = rule[rule_idx({l, c, r})];

endmodule

// File: rtl/eca_rule_engine.sv
// WIDTH-cell elementary cellular automaton with a runtime-loadable rule and a
// selectable boundary mode. It advances one generation per clock for n_gens
// generations and uses a busy/done handshake.
//   clk, rst_n      : clock, asynchronous active-low reset
//   rule_we/rule_in : rule register write (honoured in IDLE only)
//   load/seed       : load the cell state; aborts a run in progress
//   wrap            : 1 = toroidal boundary, 0 = zero-padded
//   start/n_gens    : request n_gens generations
//   busy            : high while running
//   done            : one-cycle pulse after a run completes normally
//   state_out       : cell state; bit WIDTH-1 is the leftmost cell
//   gen_count       : generations completed in the current or last run
module eca_rule_engine
  import eca_rule_engine_pkg::*;
#(
  parameter int         WIDTH        = 16,
  parameter int         CNT_W        = 8,
  parameter logic [7:0] DEFAULT_RULE = 8'h84
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rule_we,
  input  logic [7:0]       rule_in,
  input  logic             load,
  input  logic [WIDTH-1:0] seed,
  input  logic             wrap,
  input  logic             start,
  input  logic [CNT_W-1:0] n_gens,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] state_out,
  output logic [CNT_W-1:0] gen_count
);

  fsm_t             fsm_q, fsm_d;
  logic [WIDTH-1:0] cells_q, cells_d, cells_nxt;
  logic [7:0]       rule_q, rule_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [CNT_W-1:0] target_q, target_d;
  logic             done_q, done_d;

  // Cell array. The edge cells take a neighbour from the opposite end when
  // wrap is set and 0 otherwise.
  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    logic l, r;
    if (i == WIDTH - 1) begin : g_left_edge
      assign l = wrap & cells_q[0];
    end else begin : g_left
      assign l = cells_q[i+1];
    end
    if (i == 0) begin : g_right_edge
      assign r = wrap & cells_q[WIDTH-1];
    end else begin : g_right
      assign r = cells_q[i-1];
    end
    eca_cell u_cell (
      .l    (l),
      .c    (cells_q[i]),
      .r    (r),
      .rule (rule_q),
      .nxt  (cells_nxt[i])
    );
  end

  assign cnt_inc = cnt_q + 1'b1;

  always_comb begin
    fsm_d    = fsm_q;
    cells_d  = cells_q;
    rule_d   = rule_q;
    cnt_d    = cnt_q;
    target_d = target_q;
    done_d   = 1'b0;
    case (fsm_q)
      IDLE: begin
        if (load) begin
          // load wins; a start or rule write in the same cycle is dropped
          cells_d = seed;
          cnt_d   = '0;
        end else begin
          if (rule_we) rule_d = rule_in;
          if (start) begin
            cnt_d = '0;
            if (n_gens == '0) begin
              done_d = 1'b1;
            end else begin
              target_d = n_gens;
              fsm_d    = RUN;
            end
          end
        end
      end
      RUN: begin
        if (load) begin
          // abort: no done pulse
          cells_d = seed;
          cnt_d   = '0;
          fsm_d   = IDLE;
        end else begin
          cells_d = cells_nxt;
          cnt_d   = cnt_inc;
          if (cnt_inc == target_q) begin
            fsm_d  = IDLE;
            done_d = 1'b1;
          end
        end
      end
      default: fsm_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q    <= IDLE;
      cells_q  <= '0;
      rule_q   <= DEFAULT_RULE;
      cnt_q    <= '0;
      target_q <= '0;
      done_q   <= 1'b0;
    end else begin
      fsm_q    <= fsm_d;
      cells_q  <= cells_d;
      rule_q   <= rule_d;
      cnt_q    <= cnt_d;
      target_q <= target_d;
      done_q   <= done_d;
    end
  end

  assign busy      = (fsm_q == RUN);
  assign done      = done_q;
  assign state_out = cells_q;
  assign gen_count = cnt_q;

endmodule

// File: tb/tb_eca_rule_engine.sv
module tb_eca_rule_engine;
  localparam int WIDTH = 8;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             rule_we = 1'b0;
  logic [7:0]       rule_in = 8'h00;
  logic             load = 1'b0;
  logic [WIDTH-1:0] seed = '0;
  logic             wrap = 1'b0;
  logic             start = 1'b0;
  logic [CNT_W-1:0] n_gens = '0;
  logic             busy, done;
  logic [WIDTH-1:0] state_out;
  logic [CNT_W-1:0] gen_count;

  eca_rule_engine #(.WIDTH(WIDTH), .CNT_W(CNT_W), .DEFAULT_RULE(8'h84)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rule_we   (rule_we),
    .rule_in   (rule_in),
    .load      (load),
    .seed      (seed),
    .wrap      (wrap),
    .start     (start),
    .n_gens    (n_gens),
    .busy      (busy),
    .done      (done),
    .state_out (state_out),
    .gen_count (gen_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int passed = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  typedef struct {
    string      name;
    logic [7:0] rule;
    logic       we;
    logic [7:0] seed;
    logic       wrap;
    logic [7:0] n;
    logic [7:0] g1;   // state one cycle after start is accepted
    logic [7:0] fin;  // final state
    logic [7:0] gc;   // final gen_count
  } vec_t;

  vec_t vecs[8];

  // Inputs are driven at the falling edge and outputs are sampled at the
  // falling edge. Each loop iteration c observes generation c.
  task automatic do_run(input vec_t v);
    int busy_cnt, done_cnt;
    logic [7:0] g1;
    @(negedge clk);
    load = 1'b1; seed = v.seed; start = 1'b0; rule_we = 1'b0;
    @(negedge clk);
    load = 1'b0; rule_we = v.we; rule_in = v.rule; wrap = v.wrap;
    start = 1'b1; n_gens = v.n;
    @(negedge clk);
    rule_we = 1'b0; start = 1'b0;
    busy_cnt = 0; done_cnt = 0; g1 = 'x;
    for (int c = 0; c < int'(v.n) + 4; c++) begin
      if (busy) busy_cnt++;
      if (done) done_cnt++;
      if (c == 1) g1 = state_out;
      @(negedge clk);
    end
    chk({v.name, " gen1"}, g1, v.g1);
    chk({v.name, " final"}, state_out, v.fin);
    chk({v.name, " gen_count"}, gen_count, v.gc);
    chk({v.name, " busy_cycles"}, busy_cnt, v.n);
    chk({v.name, " done_pulses"}, done_cnt, 1);
  endtask

  initial begin
    int dcnt, bcnt;
    vecs[0] = '{"r84_zero",    8'h84, 1'b1, 8'h00, 1'b0, 8'd2,  8'hFF, 8'h00, 8'd2};
    vecs[1] = '{"r33_ident",   8'h33, 1'b1, 8'hA5, 1'b0, 8'd5,  8'hA5, 8'hA5, 8'd5};
    vecs[2] = '{"r55_wrap",    8'h55, 1'b1, 8'h81, 1'b1, 8'd1,  8'h03, 8'h03, 8'd1};
    vecs[3] = '{"r55_nowrap",  8'h55, 1'b1, 8'h81, 1'b0, 8'd1,  8'h02, 8'h02, 8'd1};
    vecs[4] = '{"n_zero",      8'h55, 1'b1, 8'h3C, 1'b0, 8'd0,  8'h3C, 8'h3C, 8'd0};
    vecs[5] = '{"r55_shift3",  8'h55, 1'b1, 8'h01, 1'b1, 8'd3,  8'h02, 8'h08, 8'd3};
    vecs[6] = '{"r84_edge_w1", 8'h84, 1'b1, 8'h01, 1'b1, 8'd1,  8'h7C, 8'h7C, 8'd1};
    vecs[7] = '{"r84_edge_w0", 8'h84, 1'b1, 8'h01, 1'b0, 8'd1,  8'hFC, 8'hFC, 8'd1};

    #1;
    chk("reset state_out", state_out, 8'h00);
    chk("reset gen_count", gen_count, 8'h00);
    chk("reset busy", busy, 1'b0);
    chk("reset done", done, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) do_run(vecs[i]);

    // Abort a run with load on its third RUN cycle. Starts sent in RUN are ignored.
    @(negedge clk);
    load = 1'b1; seed = 8'h01;
    @(negedge clk);
    load = 1'b0; rule_we = 1'b1; rule_in = 8'h55; wrap = 1'b1; start = 1'b1; n_gens = 8'd10;
    @(negedge clk);                       // RUN cycle 1 in progress
    rule_we = 1'b0; n_gens = 8'd2;        // stray start with a smaller count
    chk("abort busy1", busy, 1'b1);
    @(negedge clk);                       // RUN cycle 2
    start = 1'b0;
    chk("abort gen1", state_out, 8'h02);
    @(negedge clk);                       // RUN cycle 3
    chk("abort gen2", state_out, 8'h04);
    chk("abort gc2", gen_count, 8'd2);
    chk("abort busy3", busy, 1'b1);
    load = 1'b1; seed = 8'hF0;
    @(negedge clk);
    load = 1'b0;
    chk("abort state", state_out, 8'hF0);
    chk("abort gen_count", gen_count, 8'd0);
    chk("abort busy", busy, 1'b0);
    dcnt = 0; bcnt = 0;
    for (int c = 0; c < 12; c++) begin
      if (done) dcnt++;
      if (busy) bcnt++;
      @(negedge clk);
    end
    chk("abort no_done", dcnt, 0);
    chk("abort no_busy", bcnt, 0);
    chk("abort state_hold", state_out, 8'hF0);

    // Apply reset in the middle of a run that uses a non-default rule.
    @(negedge clk);
    load = 1'b1; seed = 8'hA5;
    @(negedge clk);
    load = 1'b0; rule_we = 1'b1; rule_in = 8'h33; wrap = 1'b0; start = 1'b1; n_gens = 8'd10;
    @(negedge clk);
    rule_we = 1'b0; start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("midrst busy_before", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("midrst state", state_out, 8'h00);
    chk("midrst gen_count", gen_count, 8'd0);
    chk("midrst busy", busy, 1'b0);
    chk("midrst done", done, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    dcnt = 0;
    for (int c = 0; c < 4; c++) begin
      if (done) dcnt++;
      @(negedge clk);
    end
    chk("midrst no_done", dcnt, 0);
    // The rule must be back to 84: seed 00 advances to FF in one generation.
    do_run('{"post_rst_rule", 8'h00, 1'b0, 8'h00, 1'b0, 8'd1, 8'hFF, 8'hFF, 8'd1});

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/eca_rule_engine.md
Name: eca_rule_engine

Overview:
- Parametrised successor to the fixed 3-input rule gates: a WIDTH-cell elementary cellular automaton.
- The 8-bit rule is loadable at runtime, and the boundary mode (zero-padded or toroidal) is selectable.
- Advances a seeded state one generation per clock for a requested generation count, with a busy/done handshake.
- Used as a programmable logic-rule exerciser and state generator next to the per-rule gate modules.

Parameters:
- WIDTH, 16, number of cells; minimum 3.
- CNT_W, 8, width of the generation counter and of the n_gens request.
- DEFAULT_RULE, 8'h84, rule value loaded at reset.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- rule_we  input  1  in IDLE, write rule_in into the rule register.
- rule_in  input  8  new rule value.
- load  input  1  load seed into the cell state; also aborts a run.
- seed  input  WIDTH  initial cell state.
- wrap  input  1  boundary mode, 1 = toroidal, 0 = zero-padded; sampled every RUN cycle.
- start  input  1  request n_gens generations.
- n_gens  input  CNT_W  number of generations to run.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse when a run completes.
- state_out  output  WIDTH  current cell state; bit WIDTH-1 is the leftmost cell.
- gen_count  output  CNT_W  generations completed in the current or last run.

Behaviour:
- Reset values (asynchronous, rst_n low):
  - state_out = 0, rule = DEFAULT_RULE, gen_count = 0, busy = 0, done = 0, FSM = IDLE.
- Cell update:
  - l = state[i+1], c = state[i], r = state[i-1].
  - next[i] = rule[7 - {l,c,r}]: rule bit 7 is pattern 000 and rule bit 0 is pattern 111.
  - With this mapping, 8'h84 gives 1 only for patterns 000 and 101.
  - Out-of-range neighbours: wrap=0 uses 0; wrap=1 uses state[0] as the left neighbour of cell WIDTH-1 and state[WIDTH-1] as the right neighbour of cell 0.
  - All cells update simultaneously from the old state.
- FSM states: IDLE, RUN.
- IDLE:
  - load=1: state <= seed, gen_count <= 0. load has priority over start and rule_we in the same cycle; both are then ignored.
  - Else rule_we=1: rule <= rule_in. rule_we may coincide with start; the run uses the new rule starting from its first generation.
  - start=1 with n_gens=0: no state change, gen_count <= 0, done pulses in the next cycle, FSM stays IDLE.
  - start=1 with n_gens>0: target <= n_gens, gen_count <= 0, FSM -> RUN, busy=1 from the next cycle.
- RUN, each cycle:
  - state <= next, gen_count <= gen_count+1.
  - When gen_count+1 == target: FSM -> IDLE, done pulses in the following cycle, busy drops in the same cycle.
- Latency: with start accepted at edge k, state_out holds generation g after edge k+g; done and !busy are visible after edge k+N.
- Ignored in RUN: start, rule_we, n_gens.
- load in RUN: aborts the run.
  - state <= seed, gen_count <= 0, FSM -> IDLE.
  - No done pulse.
- Reset mid-run returns all outputs to their reset values immediately; no done pulse.
- gen_count never exceeds target and never wraps.

Decomposition:
- Shared package: FSM state enum (IDLE, RUN) and the rule-index helper 7 - pattern.
- Natural sub-module: eca_cell, a combinational 3-input rule lookup (l, c, r, rule[7:0] -> next), instantiated WIDTH times by a generate loop.

Test Plan (WIDTH=8):
- Reset, then seed 8'h00, rule 8'h84, wrap=0, start n_gens=2 -> state_out FF after 1 cycle, 00 after 2; done pulses once; gen_count=2; busy high exactly 2 cycles.
- rule_we 8'h33 (identity), seed A5, n_gens=5 -> state_out stays A5 throughout, gen_count=5, single done pulse.
- rule_we 8'h55 (take right neighbour), seed 81, n_gens=1 -> wrap=1 gives 03; repeat with wrap=0 gives 02.
- start with n_gens=0 -> done pulses in the next cycle, busy never asserted, state_out unchanged.
- rule 8'h55, wrap=1, seed 01, n_gens=10; assert load with seed F0 on the 3rd RUN cycle -> busy drops, no done, state_out=F0, gen_count=0; start pulses during RUN are ignored.
- Drop rst_n mid-run -> state_out=0, rule reads back 84 (check with seed 00, one generation -> FF), busy=0, done=0.
